asm_frame_sched: RTL and testbench

- Sequencer for the ASM bit-frame buffer (dual-port, 1 bit wide, 1-cycle read latency) that sits between the serial input and the interleaved read-out.
- A one-cycle din_vld start pulse arms capture of N_BITS consecutive din bits. The block generates write enables and addresses for the capture.
- After capture, each cycle with request high issues one read. Each read drives a sequential address (rdata path) and an interleaved address (rdata_itl path) derived from the latched link_id.

---
 rtl/asm_frame_sched.sv | 117 +++++++++++
 tb/tb_asm_frame_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/asm_frame_sched.sv
// Capture/read-out sequencer for the 1-bit ASM frame buffer: writes N_BITS bits after a
// start pulse, then issues sequential + interleaved reads. Optional err_cnt via ASM_SCHED_ERRCNT_EN.
module asm_frame_sched #(
  parameter int N_BITS = 256,
  parameter int AW     = 8,
  parameter int STRIDE = 37
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [5:0]    link_id,
  input  logic          din_vld,
  input  logic          request,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic          ren,
  output logic [AW-1:0] raddr,
  output logic [AW-1:0] raddr_itl,
  output logic          rd_vld,
  output logic          full,
  output logic          busy,
  output logic          frame_done,
  output logic [5:0]    link_id_q,
`ifdef ASM_SCHED_ERRCNT_EN
  output logic [7:0]    err_cnt,
`endif
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {IDLE, WRITE, FULL, READ} state_t;

  localparam logic [AW-1:0] LAST = AW'(N_BITS - 1);
  localparam logic [AW-1:0] STEP = AW'(STRIDE);

  state_t        state, next_state;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] itl_acc;
  logic          start;
  logic          issue;

  // Handshake: request is a strobe with no back-pressure. Every edge with request=1 in
  // FULL/READ is one accepted read; ren/raddr/raddr_itl are registered on that edge and
  // rd_vld (buffer data valid) follows one cycle later. Requests elsewhere are dropped.
  assign start = (state == IDLE) && din_vld;
  assign issue = ((state == FULL) || (state == READ)) && request;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (din_vld) next_state = WRITE;
      WRITE: if (wr_cnt == LAST) next_state = FULL;
      FULL, READ: begin
        if (request) next_state = (rd_cnt == LAST) ? IDLE : READ;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      itl_acc    <= '0;
      link_id_q  <= '0;
      ren        <= 1'b0;
      raddr      <= '0;
      raddr_itl  <= '0;
      rd_vld     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rd_vld     <= ren;
      // raddr reaches LAST only on the final read of a frame
      frame_done <= ren && (raddr == LAST);
      ren        <= issue;
      if (start) begin
        link_id_q <= link_id;
        wr_cnt    <= '0;
        itl_acc   <= AW'({link_id, 2'b00});
      end
      if (state == WRITE) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST) rd_cnt <= '0;
      end
      if (issue) begin
        raddr     <= rd_cnt;
        raddr_itl <= itl_acc;
        rd_cnt    <= rd_cnt + 1'b1;
        itl_acc   <= itl_acc + STEP;
      end
    end
  end

  assign wen       = (state == WRITE);
  assign waddr     = wr_cnt;
  assign full      = (state == FULL) || (state == READ);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

`ifdef ASM_SCHED_ERRCNT_EN
  logic err_evt;

  // Both ignored-event kinds on one edge count once.
  assign err_evt = (din_vld && (state != IDLE)) ||
                   (request && ((state == IDLE) || (state == WRITE)));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                              err_cnt <= 8'd0;
    else if (err_evt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_asm_frame_sched.sv
// Self-checking bench for asm_frame_sched: randomized request gaps checked against an
// arithmetic model of the read address sequence.
module tb_asm_frame_sched;
  localparam int N      = 256;
  localparam int AW     = 8;
  localparam int STRIDE = 37;

  // clock/reset block
  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [5:0]    link_id = '0;
  logic          din_vld = 1'b0;
  logic          request = 1'b0;
  logic          wen, ren, rd_vld, full, busy, frame_done;
  logic [AW-1:0] waddr, raddr, raddr_itl;
  logic [5:0]    link_id_q;
  logic [1:0]    state_dbg;
`ifdef ASM_SCHED_ERRCNT_EN
  logic [7:0]    err_cnt;
`endif

  always #5 clk = ~clk;

  asm_frame_sched #(.N_BITS(N), .AW(AW), .STRIDE(STRIDE)) dut (
    .clk(clk), .n_rst(n_rst), .link_id(link_id), .din_vld(din_vld), .request(request),
    .wen(wen), .waddr(waddr), .ren(ren), .raddr(raddr), .raddr_itl(raddr_itl),
    .rd_vld(rd_vld), .full(full), .busy(busy), .frame_done(frame_done),
    .link_id_q(link_id_q),
`ifdef ASM_SCHED_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // scoreboard / reference model state
  int            errors = 0;
  int            checks = 0;
  logic [AW-1:0] exp_q[$];
  int            link_cur;
  int            k_rd;
  bit            prev_issue;
  bit            prev_last;
  int            cnt_itl[N];
  int            done_cnt = 0;
  int            exp_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one cycle of the read phase; model says read k goes to k and
  // (link*4 + k*STRIDE) mod N
  task automatic read_cycle(input bit req);
    logic [AW-1:0] exp_itl;
    request = req;
    if (req) exp_q.push_back(AW'((link_cur * 4 + k_rd * STRIDE) % N));
    tick();
    request = 1'b0;
    checks++;
    if (rd_vld !== prev_issue) begin
      errors++; $display("FAIL rd_vld k=%0d: got %b exp %b", k_rd, rd_vld, prev_issue);
    end
    checks++;
    if (frame_done !== prev_last) begin
      errors++; $display("FAIL frame_done k=%0d: got %b exp %b", k_rd, frame_done, prev_last);
    end
    checks++;
    if (ren !== req) begin
      errors++; $display("FAIL ren k=%0d: got %b exp %b", k_rd, ren, req);
    end
    prev_last = 1'b0;
    if (req) begin
      exp_itl = exp_q.pop_front();
      checks++;
      if (raddr !== k_rd[AW-1:0]) begin
        errors++; $display("FAIL raddr: got %0d exp %0d", raddr, k_rd);
      end
      checks++;
      if (raddr_itl !== exp_itl) begin
        errors++; $display("FAIL raddr_itl k=%0d: got %0d exp %0d", k_rd, raddr_itl, exp_itl);
      end
      if (!$isunknown(raddr_itl)) cnt_itl[raddr_itl]++;
      prev_last = (k_rd == N - 1);
      k_rd++;
    end
    prev_issue = req;
    checks++;
    if (busy !== (k_rd < N) || full !== (k_rd < N)) begin
      errors++; $display("FAIL busy_full k=%0d: got %b%b exp %b", k_rd, busy, full, (k_rd < N));
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #2;
    checks++;
    if ({wen, ren, rd_vld, full, busy, frame_done} !== 6'b0 ||
        {waddr, raddr, raddr_itl, link_id_q} !== '0) begin
      errors++; $display("FAIL reset_outputs: got ctl=%b addr=%h/%h/%h id=%h exp zero",
        {wen, ren, rd_vld, full, busy, frame_done}, waddr, raddr, raddr_itl, link_id_q);
    end
`ifdef ASM_SCHED_ERRCNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_err_cnt: got %0d exp 0", err_cnt);
    end
`endif
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_capture(input int link, input bit inject, input bit tail);
    link_cur = link; k_rd = 0; prev_issue = 1'b0; prev_last = 1'b0;
    exp_q.delete();
    foreach (cnt_itl[i]) cnt_itl[i] = 0;
    if (!tail) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL idle_busy: got %b exp 0", busy);
      end
    end
    link_id = 6'(link);
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    link_id = 6'($urandom_range(0, 63));
    if (tail) begin
      checks++;
      if (rd_vld !== 1'b1 || frame_done !== 1'b1) begin
        errors++; $display("FAIL tail_rd_vld: got rd_vld=%b done=%b exp 1 1", rd_vld, frame_done);
      end
      if (frame_done === 1'b1) done_cnt++;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (wen !== 1'b1 || waddr !== i[AW-1:0]) begin
        errors++; $display("FAIL capture i=%0d: got wen=%b waddr=%0d exp 1 %0d", i, wen, waddr, i);
      end
      checks++;
      if (ren !== 1'b0 || full !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL capture_ctl i=%0d: got ren=%b full=%b busy=%b exp 0 0 1",
          i, ren, full, busy);
      end
      if (inject && i == 10) begin din_vld = 1'b1; exp_err++; end
      if (inject && i == 20) begin request = 1'b1; exp_err++; end
      tick();
      din_vld = 1'b0;
      request = 1'b0;
    end
    checks++;
    if (wen !== 1'b0 || full !== 1'b1 || busy !== 1'b1 || ren !== 1'b0) begin
      errors++; $display("FAIL captured: got wen=%b full=%b busy=%b ren=%b exp 0 1 1 0",
        wen, full, busy, ren);
    end
    checks++;
    if (link_id_q !== 6'(link)) begin
      errors++; $display("FAIL link_id_q: got %0d exp %0d", link_id_q, link);
    end
`ifdef ASM_SCHED_ERRCNT_EN
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      errors++; $display("FAIL err_cnt: got %0d exp %0d", err_cnt, exp_err);
    end
`endif
  endtask

  task automatic test_read_burst();
    logic [AW-1:0] got[3];
    logic [AW-1:0] want[3];
    want[0] = 8'd20; want[1] = 8'd57; want[2] = 8'd94;
    for (int j = 0; j < 3; j++) begin
      read_cycle(1'b1);
      got[j] = raddr_itl;
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (got[j] !== want[j]) begin
        errors++; $display("FAIL burst_itl[%0d]: got %0d exp %0d", j, got[j], want[j]);
      end
    end
    read_cycle(1'b0);
  endtask

  task automatic test_request_pattern();
    logic [11:0] pat;
    pat = 12'b1000_1101_1111;
    for (int j = 11; j >= 0; j--) read_cycle(pat[j]);
  endtask

  task automatic test_full_frame();
    int bad;
    for (int c = 0; c < 4000 && k_rd < N; c++) read_cycle(1'($urandom_range(0, 1)));
    checks++;
    if (k_rd != N) begin
      errors++; $display("FAIL frame_reads: got %0d exp %0d", k_rd, N);
    end
    bad = 0;
    foreach (cnt_itl[i]) if (cnt_itl[i] != 1) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL itl_coverage: got %0d addresses not seen once exp 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    test_capture($urandom_range(0, 63), 1'b1, 1'b1);
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL frame_done_count: got %0d exp 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid_read();
    for (int c = 0; c < 2000 && k_rd < 100; c++) read_cycle(1'($urandom_range(0, 1)));
    n_rst = 1'b0;
    #1;
    checks++;
    if ({wen, ren, rd_vld, full, busy, frame_done} !== 6'b0 ||
        {waddr, raddr, raddr_itl, link_id_q} !== '0) begin
      errors++; $display("FAIL mid_reset: got ctl=%b addr=%h/%h/%h id=%h exp zero",
        {wen, ren, rd_vld, full, busy, frame_done}, waddr, raddr, raddr_itl, link_id_q);
    end
    exp_err = 0;
`ifdef ASM_SCHED_ERRCNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_reset_err_cnt: got %0d exp 0", err_cnt);
    end
`endif
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_restart_link0();
    test_capture(0, 1'b0, 1'b0);
    read_cycle(1'b1);
    checks++;
    if (raddr_itl !== '0) begin
      errors++; $display("FAIL restart_itl: got %0d exp 0", raddr_itl);
    end
  endtask

  initial begin
    test_reset();
    test_capture(5, 1'b0, 1'b0);
    test_read_burst();
    test_request_pattern();
    test_full_frame();
    test_back_to_back();
    test_reset_mid_read();
    test_restart_link0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
